// File: rtl/dec_addr_looper.sv
// Address sequencer for LWE decryption m = c2 - <c1, s> (negacyclic), k/i/j nested walk.
// Optional coef_final flag is built only when DEC_COEF_FINAL_EN is defined.
module dec_addr_looper #(
    parameter int unsigned DEPTH = 100,
    parameter int unsigned K     = 500
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        begin_dec,
    input  logic        stall_in,
    output logic        ready,
    output logic [16:0] c_addr,
    output logic [16:0] s_addr,
    output logic [6:0]  c2_addr,
    output logic [6:0]  m_addr,
    output logic        neg,
    output logic        load_c2,
    output logic        coef_final,
    output logic        addr_valid,
    output logic        done
);
    localparam int unsigned HALF_DEPTH = DEPTH / 2;
    localparam int unsigned KW         = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e          state_q, state_d;
    logic [6:0]      i_q, j_q;
    logic [KW-1:0]   k_q;
    logic            beat, last_j, last_i, last_k;

    logic [7:0]      sum_d;
    logic [16:0]     kbase_d, c_addr_d, s_addr_d;
    logic [6:0]      m_addr_d;
    logic            neg_d, load_c2_d, coef_final_d;

    assign beat   = (state_q == StRun) && !stall_in;
    assign last_j = (j_q == 7'(HALF_DEPTH - 1));
    assign last_i = (i_q == 7'(HALF_DEPTH - 1));
    assign last_k = (k_q == KW'(K - 1));
    assign ready  = (state_q == StIdle);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (begin_dec) state_d = StRun;
            StRun:   if (beat && last_j && last_i && last_k) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || (state_q == StIdle && begin_dec)) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else if (beat) begin
            if (last_j) begin
                j_q <= '0;
                if (last_i) begin
                    i_q <= '0;
                    k_q <= last_k ? '0 : k_q + 1'b1;
                end else begin
                    i_q <= i_q + 7'd1;
                end
            end else begin
                j_q <= j_q + 7'd1;
            end
        end
    end

    // Sum kept at 8 bits so the wrap test happens before any subtraction.
    always_comb begin
        sum_d     = {1'b0, i_q} + {1'b0, j_q};
        neg_d     = (sum_d >= 8'(HALF_DEPTH));
        m_addr_d  = neg_d ? 7'(sum_d - 8'(HALF_DEPTH)) : sum_d[6:0];
        kbase_d   = 17'(k_q) * 17'(HALF_DEPTH);
        c_addr_d  = kbase_d + 17'(i_q);
        s_addr_d  = kbase_d + 17'(j_q);
        load_c2_d = (k_q == '0) && (i_q == '0);
`ifdef DEC_COEF_FINAL_EN
        coef_final_d = last_k && last_i;
`else
        coef_final_d = 1'b0;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_valid <= 1'b0;
            done       <= 1'b0;
            c_addr     <= '0;
            s_addr     <= '0;
            c2_addr    <= '0;
            m_addr     <= '0;
            neg        <= 1'b0;
            load_c2    <= 1'b0;
            coef_final <= 1'b0;
        end else begin
            addr_valid <= beat;
            done       <= (state_q == StFin);
            if (beat) begin
                c_addr     <= c_addr_d;
                s_addr     <= s_addr_d;
                c2_addr    <= j_q;
                m_addr     <= m_addr_d;
                neg        <= neg_d;
                load_c2    <= load_c2_d;
                coef_final <= coef_final_d;
            end
        end
    end

endmodule

// File: doc/dec_addr_looper.md
Name: dec_addr_looper

Overview:
- Address sequencer for LWE decryption: computes m = c2 - <c1, s>, negacyclic, over K blocks of HALF_DEPTH coefficients.
- Walks three nested indices (k outermost, i middle, j innermost) and emits registered addresses into the ciphertext c1 RAM, secret-key s RAM, c2 RAM and message-accumulator RAM.
- Drives a downstream multiply-accumulate datapath.
- Counterpart to the encryption address looper on the encrypt side of the same memory layout.

Parameters:
- DEPTH, 100, polynomial depth; HALF_DEPTH = DEPTH/2 coefficients per block.
- K, 500, number of blocks in the outer loop.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- begin_dec  input  1  start pulse; accepted only in IDLE.
- stall_in  input  1  downstream back-pressure; holds the sequence.
- ready  output  1  high in IDLE.
- c_addr  output  17  c1 address, k*HALF_DEPTH + i.
- s_addr  output  17  s address, k*HALF_DEPTH + j.
- c2_addr  output  7  c2 address, equal to j.
- m_addr  output  7  accumulator address, (i+j) mod HALF_DEPTH.
- neg  output  1  high when i+j >= HALF_DEPTH (negacyclic sign flip on the product).
- load_c2  output  1  high when k==0 and i==0 (accumulator seeded with c2 term).
- coef_final  output  1  last contribution to m_addr (see Optional Feature).
- addr_valid  output  1  address beat valid this cycle.
- done  output  1  one-cycle pulse after the last beat.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high on rst_in.
- Reset values: all outputs 0 except ready=1; FSM in IDLE; i, j, k = 0.
  - rst_in mid-RUN aborts to IDLE on the next edge, with no done pulse.
- FSM states: IDLE, RUN, FIN.
  - IDLE: on begin_dec, clear i, j, k and go to RUN. ready=1.
  - RUN: each cycle with stall_in=0, register the outputs for the current (k,i,j), set addr_valid=1, then advance the counters.
  - RUN with stall_in=1: counters hold and addr_valid=0 on the next cycle. Address outputs may hold their last value.
  - RUN -> FIN after the beat (K-1, HALF_DEPTH-1, HALF_DEPTH-1) is issued.
  - FIN: done=1 and addr_valid=0 for one cycle, then go to IDLE.
- Latency: begin_dec sampled at edge T; first addr_valid (k=i=j=0) is visible in the cycle after edge T+1.
- Beat count: exactly K*HALF_DEPTH*HALF_DEPTH valid beats, strictly in order; stalls never skip or repeat a beat.
- Counter advance: j increments every beat.
  - j wraps HALF_DEPTH-1 -> 0 and increments i.
  - i wraps the same way and increments k.
  - k wraps at K-1 only at end of sequence.
- Arithmetic: i+j is computed at 8 bits, before any subtraction.
  - m_addr = i+j-HALF_DEPTH when neg=1, else i+j.
  - The k*HALF_DEPTH product is formed at 17 bits, with no truncation for the defaults.
- Ignored inputs:
  - begin_dec in RUN or FIN is ignored and does not restart the sequence.
  - stall_in in IDLE or FIN is ignored.
- Simultaneous begin_dec and stall_in in IDLE: the start is accepted; the first beat is delayed until stall_in drops.

Optional Feature:
- Macro: DEC_COEF_FINAL_EN.
- Defined: coef_final=1 on beats with k==K-1 and i==HALF_DEPTH-1. This is the final contribution to that m_addr, so downstream may read out the decoded coefficient.
- Undefined: coef_final is tied to 0 and no extra compare logic is built.

Test Plan:
- Full sequence, DEPTH=4, K=2 (HALF_DEPTH=2), pulse begin_dec, no stall:
  - exactly 8 addr_valid beats;
  - (k,i,j)=(0,0,0): c_addr=0, s_addr=0, m_addr=0, neg=0, load_c2=1;
  - (0,1,1): m_addr=0, neg=1, load_c2=0;
  - (1,1,0): c_addr=3, s_addr=2, m_addr=1;
  - done pulses once in the cycle after beat 8, then ready=1.
- Stall, same params: hold stall_in=1 for 3 cycles after beat 3:
  - addr_valid=0 for those 3 cycles;
  - beat 4 resumes with (0,1,1);
  - total still 8 beats; done 3 cycles later than the no-stall case.
- Start during RUN: begin_dec at beat 5 -> ignored; sequence and done unchanged.
- Reset mid-op: rst_in at beat 4 -> next cycle addr_valid=0, ready=1, no done; a new begin_dec restarts at (0,0,0).
- Defaults (DEPTH=100, K=500):
  - exactly 1,250,000 beats;
  - last beat c_addr=24999, s_addr=24999, m_addr=48, neg=1.
- DEC_COEF_FINAL_EN, DEPTH=4, K=2:
  - defined: coef_final high only on beats (1,1,0) and (1,1,1);
  - undefined: coef_final is always 0.
